row_mult_seq: RTL and testbench
===============================

ROW_MULT_SEQ -- requirements
Module: row_mult_seq

Interface
REQ-001 SHALL have parameter W, default 27, data word width.
REQ-002 SHALL have parameter N, default 6, row length in elements.
REQ-003 SHALL have parameter LANES, default 3, number of external multiplier lanes.
REQ-004 SHALL have parameter MULT_LAT, default 5, external multiplier latency in enabled cycles, minimum 1.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port en  input  1  global clock enable; shares en with the external multipliers.
REQ-008 SHALL have port start  input  1  request new operation.
REQ-009 SHALL have port mode  input  1  0 = row times scalar, 1 = element-wise row times row.
REQ-010 SHALL have port row_a  input  N x W  first operand row.
REQ-011 SHALL have port row_b  input  N x W  second operand row, used when mode=1.
REQ-012 SHALL have port scalar  input  W  scalar operand, used when mode=0.
REQ-013 SHALL have port mult_dataa  output  LANES x W  multiplier operand A.
REQ-014 SHALL have port mult_datab  output  LANES x W  multiplier operand B.
REQ-015 SHALL have port mult_result  input  LANES x W  multiplier products.
REQ-016 SHALL have port busy  output  1  operation in progress.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 SHALL have port result  output  N x W  product row.

Function
REQ-019 SHALL define B = ceil(N/LANES) beats per operation; beat k covers elements k*LANES .. k*LANES+LANES-1.
REQ-020 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-021 SHALL freeze all state, counters and outputs in any cycle with en=0; en-low cycles count toward no latency.
REQ-022 SHALL, in IDLE or DONE with en=1 and start=1, snapshot row_a, row_b, scalar and mode, then enter ISSUE.
REQ-023 SHALL ignore start while in ISSUE or DRAIN.
REQ-024 SHALL drive beat k operands on mult_dataa/mult_datab during the k-th enabled ISSUE cycle; in mode=0 every used lane of mult_datab carries scalar.
REQ-025 SHALL drive zero on lanes whose element index is at least N, and on all lanes outside ISSUE.
REQ-026 SHALL leave ISSUE for DRAIN after beat B-1.
REQ-027 SHALL capture mult_result for beat k exactly MULT_LAT enabled cycles after beat k issue into result, writing only element indices below N.
REQ-028 SHALL enter DONE after capturing beat B-1; done=1 for that one cycle only, result stable from then until the next capture.
REQ-029 SHALL give done exactly B+MULT_LAT+1 enabled cycles after the start cycle; 8 cycles for default parameters.
REQ-030 SHALL hold busy=1 in ISSUE and DRAIN only.
REQ-031 SHALL return DONE to IDLE on the next enabled cycle unless start=1, in which case it SHALL start back-to-back.
REQ-032 SHALL keep result unchanged from DONE until the first capture of a following operation.
REQ-033 SHALL pass products through bit-exact with no width conversion; arithmetic format belongs to the multipliers.

Reset
REQ-034 SHALL, on rst=1, go to IDLE immediately, clear busy, done, result, mult_dataa, mult_datab, all counters and the delay line.
REQ-035 SHALL abort an in-flight operation on rst with no done pulse, and SHALL never capture products issued before reset.

Structure
REQ-036 SHALL take W, word type and the state enum from shared package inverse_pkg.
REQ-037 SHALL hold the MULT_LAT-deep valid-plus-beat-index delay line in sub-module mult_lat_pipe, clock-enabled by en.

Verification
REQ-038 Bench SHALL model the multipliers as an integer product modulo 2^W with MULT_LAT delay under en.
REQ-039 Scenario, mode 0: row_a = 1..6, scalar = 2, en held 1 -> done at cycle 8, result = 2,4,6,8,10,12, busy high cycles 1-7.
REQ-040 Scenario, mode 1: row_a = 1..6, row_b = 6..1 -> result = 6,10,12,12,10,6.
REQ-041 Scenario, en toggling every other cycle during the mode-0 case -> identical result, done at enabled cycle 8; start during busy is ignored.
REQ-042 Scenario, back-to-back: start held high through DONE with new scalar 3 -> second done 8 enabled cycles later, result = 3,6,9,12,15,18.
REQ-043 Scenario, rst asserted in DRAIN, then start with scalar 1 -> no done before reset release, result 0 after reset, then result = 1..6.
REQ-044 Scenario, N=7, LANES=3 -> B=3; lanes 1-2 of beat 2 drive 0; done at cycle 9; result correct for 7 elements.

Source files
------------

// File: rtl/inverse_pkg.sv
// Shared word type, FSM state encoding and sizing helper for the row multiplier family.
package inverse_pkg;

  localparam int unsigned DATA_W = 27;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/mult_lat_pipe.sv
// Valid + beat-index delay line matching the external multiplier latency; advances only when en=1.
module mult_lat_pipe #(
  parameter int unsigned LAT = 5,
  parameter int unsigned BW  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  input  logic [BW-1:0] in_beat,
  output logic          out_valid,
  output logic [BW-1:0] out_beat
);

  localparam int unsigned DW = LAT * BW;

  logic [LAT-1:0] valid_q, valid_d;
  logic [DW-1:0]  beat_q,  beat_d;

  // Shift in at the bottom; the oldest entry sits in the top slot.
  always_comb begin
    valid_d = LAT'({valid_q, in_valid});
    beat_d  = DW'({beat_q, in_beat});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      beat_q  <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_beat  = beat_q[DW-1 -: BW];

endmodule

// File: rtl/row_mult_seq.sv
// Row times scalar / element-wise row times row, issued LANES elements per beat to external
// pipelined multipliers and gathered back into a registered result row.
module row_mult_seq
  import inverse_pkg::*;
#(
  parameter int unsigned W        = DATA_W,
  parameter int unsigned N        = 6,
  parameter int unsigned LANES    = 3,
  parameter int unsigned MULT_LAT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               mode,
  input  logic [N*W-1:0]     row_a,
  input  logic [N*W-1:0]     row_b,
  input  logic [W-1:0]       scalar,
  output logic [LANES*W-1:0] mult_dataa,
  output logic [LANES*W-1:0] mult_datab,
  input  logic [LANES*W-1:0] mult_result,
  output logic               busy,
  output logic               done,
  output logic [N*W-1:0]     result
);

  localparam int unsigned B  = ceil_div(N, LANES);
  localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(B - 1);

  state_e             state_q,  state_d;
  logic [BW-1:0]      beat_q,   beat_d;
  logic               mode_q,   mode_d;
  logic [W-1:0]       scalar_q, scalar_d;
  logic [N*W-1:0]     row_a_q,  row_a_d;
  logic [N*W-1:0]     row_b_q,  row_b_d;
  logic [LANES*W-1:0] dataa_q,  dataa_d;
  logic [LANES*W-1:0] datab_q,  datab_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [N*W-1:0]     result_q, result_d;

  logic          pipe_valid;
  logic [BW-1:0] pipe_beat;

  mult_lat_pipe #(
    .LAT (MULT_LAT),
    .BW  (BW)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (state_q == ST_ISSUE),
    .in_beat   (beat_q),
    .out_valid (pipe_valid),
    .out_beat  (pipe_beat)
  );

  always_comb begin
    int unsigned cap_idx;
    int unsigned iss_idx;
    state_d  = state_q;
    beat_d   = beat_q;
    mode_d   = mode_q;
    scalar_d = scalar_q;
    row_a_d  = row_a_q;
    row_b_d  = row_b_q;
    result_d = result_q;
    dataa_d  = '0;
    datab_d  = '0;
    cap_idx  = 0;
    iss_idx  = 0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_ISSUE;
          beat_d   = '0;
          mode_d   = mode;
          scalar_d = scalar;
          row_a_d  = row_a;
          row_b_d  = row_b;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (beat_q == LAST_BEAT) state_d = ST_DRAIN;
        else                     beat_d  = beat_q + BW'(1);
      end
      ST_DRAIN: begin
        if (pipe_valid && (pipe_beat == LAST_BEAT)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Products come back tagged by the delay line; lanes past the row end are dropped.
    if (pipe_valid) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        cap_idx = 32'(pipe_beat) * LANES + l;
        if (cap_idx < N) result_d[cap_idx*W +: W] = mult_result[l*W +: W];
      end
    end

    // Operands are registered, so they are prepared for the beat the next cycle will issue.
    if (state_d == ST_ISSUE) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        iss_idx = 32'(beat_d) * LANES + l;
        if (iss_idx < N) begin
          dataa_d[l*W +: W] = row_a_d[iss_idx*W +: W];
          datab_d[l*W +: W] = mode_d ? row_b_d[iss_idx*W +: W] : scalar_d;
        end
      end
    end

    busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      mode_q   <= 1'b0;
      scalar_q <= '0;
      row_a_q  <= '0;
      row_b_q  <= '0;
      dataa_q  <= '0;
      datab_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (en) begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      mode_q   <= mode_d;
      scalar_q <= scalar_d;
      row_a_q  <= row_a_d;
      row_b_q  <= row_b_d;
      dataa_q  <= dataa_d;
      datab_q  <= datab_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign mult_dataa = dataa_q;
  assign mult_datab = datab_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;

endmodule

// File: tb/tb_row_mult_seq.sv
// Bench for row_mult_seq: external multipliers modelled as delayed products, a transaction-level
// reference for the default instance, and directed literal checks including an N=7 instance.
module tb_row_mult_seq;
  import inverse_pkg::*;

  localparam int W   = 27;
  localparam int L   = 5;
  localparam int LN  = 3;
  localparam int NB  = 2;
  localparam int DONE_T = NB + L + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic start = 1'b0;
  logic start7 = 1'b0;
  logic mode = 1'b0;
  logic [6*W-1:0] row_a = '0, row_b = '0;
  logic [7*W-1:0] row_a7 = '0, row_b7 = '0;
  logic [W-1:0] scalar = '0, scalar7 = '0;

  logic [LN*W-1:0] mult_dataa, mult_datab, mult_result;
  logic [LN*W-1:0] mult_dataa7, mult_datab7, mult_result7;
  logic busy, done, busy7, done7;
  logic [6*W-1:0] result;
  logic [7*W-1:0] result7;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  row_mult_seq #(.W(W), .N(6), .LANES(LN), .MULT_LAT(L)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode),
    .row_a(row_a), .row_b(row_b), .scalar(scalar),
    .mult_dataa(mult_dataa), .mult_datab(mult_datab), .mult_result(mult_result),
    .busy(busy), .done(done), .result(result));

  row_mult_seq #(.W(W), .N(7), .LANES(LN), .MULT_LAT(L)) dut7 (
    .clk(clk), .rst(rst), .en(en), .start(start7), .mode(mode),
    .row_a(row_a7), .row_b(row_b7), .scalar(scalar7),
    .mult_dataa(mult_dataa7), .mult_datab(mult_datab7), .mult_result(mult_result7),
    .busy(busy7), .done(done7), .result(result7));

  // External multipliers: per-lane product modulo 2^W, L enabled cycles deep, never reset.
  function automatic logic [LN*W-1:0] mul3(input logic [LN*W-1:0] a, input logic [LN*W-1:0] b);
    logic [LN*W-1:0] r;
    for (int l = 0; l < LN; l++) r[l*W +: W] = W'(a[l*W +: W] * b[l*W +: W]);
    return r;
  endfunction

  logic [LN*W-1:0] mp [L];
  logic [LN*W-1:0] mp7 [L];
  always @(posedge clk) begin
    if (en) begin
      mp[0]  <= mul3(mult_dataa, mult_datab);
      mp7[0] <= mul3(mult_dataa7, mult_datab7);
      for (int i = 1; i < L; i++) begin
        mp[i]  <= mp[i-1];
        mp7[i] <= mp7[i-1];
      end
    end
  end
  assign mult_result  = mp[L-1];
  assign mult_result7 = mp7[L-1];

  // Reference for the N=6 instance: t counts enabled cycles since the start was accepted.
  bit     m_act = 1'b0;
  int     m_t = 0;
  word_t  m_a [6];
  word_t  m_b [6];
  word_t  m_old [6];
  word_t  m_new [6];

  function automatic word_t vis(input int i);
    return (m_act && m_t >= i / LN + L + 2) ? m_new[i] : m_old[i];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0;
      m_t   <= 0;
      for (int i = 0; i < 6; i++) begin
        m_old[i] <= '0;
        m_new[i] <= '0;
        m_a[i]   <= '0;
        m_b[i]   <= '0;
      end
    end else if (en) begin
      if ((!m_act || m_t == DONE_T) && start) begin
        m_act <= 1'b1;
        m_t   <= 1;
        for (int i = 0; i < 6; i++) begin
          m_old[i] <= vis(i);
          m_a[i]   <= row_a[i*W +: W];
          m_b[i]   <= mode ? row_b[i*W +: W] : scalar;
          m_new[i] <= W'(row_a[i*W +: W] * (mode ? row_b[i*W +: W] : scalar));
        end
      end else if (m_act) begin
        if (m_t == DONE_T) begin
          m_act <= 1'b0;
          for (int i = 0; i < 6; i++) m_old[i] <= m_new[i];
        end else begin
          m_t <= m_t + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7*W-1:0] act, input logic [7*W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the N=6 instance against the reference.
  initial begin
    forever begin
      logic [7*W-1:0] er, ea, eb;
      int e;
      @(posedge clk);
      #2;
      er = '0; ea = '0; eb = '0;
      for (int i = 0; i < 6; i++) er[i*W +: W] = vis(i);
      if (m_act && m_t >= 1 && m_t <= NB) begin
        for (int l = 0; l < LN; l++) begin
          e = (m_t - 1) * LN + l;
          if (e < 6) begin
            ea[l*W +: W] = m_a[e];
            eb[l*W +: W] = m_b[e];
          end
        end
      end
      chk("model_busy", (7*W)'(busy), (7*W)'(m_act && m_t >= 1 && m_t <= NB + L));
      chk("model_done", (7*W)'(done), (7*W)'(m_act && m_t == DONE_T));
      chk("model_result", (7*W)'(result), er);
      chk("model_dataa", (7*W)'(mult_dataa), ea);
      chk("model_datab", (7*W)'(mult_datab), eb);
    end
  end

  function automatic logic [7*W-1:0] mk7(input int e0, e1, e2, e3, e4, e5, e6);
    logic [7*W-1:0] r;
    r = '0;
    r[0*W +: W] = W'(e0); r[1*W +: W] = W'(e1); r[2*W +: W] = W'(e2);
    r[3*W +: W] = W'(e3); r[4*W +: W] = W'(e4); r[5*W +: W] = W'(e5);
    r[6*W +: W] = W'(e6);
    return r;
  endfunction

  // Caller raises start at a negedge; returns after done with enabled-cycle and busy counts.
  task automatic run_op(input bit sel, input bit tog, input int spur_at,
                        output int cyc, output int bcyc,
                        output logic [LN*W-1:0] a3, output logic [LN*W-1:0] b3);
    bit we;
    bit got;
    cyc = 0; bcyc = 0; got = 0; a3 = '0; b3 = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      we = en;
      #2;
      if (we) begin
        cyc++;
        if (sel ? busy7 : busy) bcyc++;
        if (cyc == 3) begin
          a3 = sel ? mult_dataa7 : mult_dataa;
          b3 = sel ? mult_datab7 : mult_datab;
        end
        if (sel ? done7 : done) got = 1;
        start  = 1'b0;
        start7 = 1'b0;
      end
      if (!got) begin
        @(negedge clk);
        if (tog) en = ~en;
        if (cyc == spur_at) begin
          start  = 1'b1;
          scalar = W'(5);
        end
      end
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL op_timeout: got no done, required done within 100 cycles");
    end
  endtask

  task automatic set_rows(input int sa, input int sb, input int sc);
    for (int i = 0; i < 6; i++) begin
      row_a[i*W +: W] = W'(i + 1);
      row_b[i*W +: W] = W'(6 - i);
    end
    scalar = W'(sc);
    if (sa != 0 || sb != 0) mode = (sb != 0);
  endtask

  task automatic go_idle();
    @(negedge clk);
    en = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int cyc, bcyc;
    logic [LN*W-1:0] a3, b3;
    bit dseen;

    repeat (2) @(posedge clk);
    #2;
    chk("reset_result", (7*W)'(result), '0);
    chk("reset_busy", (7*W)'(busy), '0);
    chk("reset_done", (7*W)'(done), '0);
    chk("reset_dataa", (7*W)'(mult_dataa), '0);
    @(negedge clk);
    rst = 1'b0;
    go_idle();

    // Mode 0, row times scalar 2
    set_rows(1, 0, 2);
    start = 1'b1;
    run_op(1'b0, 1'b0, -1, cyc, bcyc, a3, b3);
    chk("m0_done_cycle", (7*W)'(cyc), (7*W)'(8));
    chk("m0_busy_cycles", (7*W)'(bcyc), (7*W)'(7));
    chk("m0_result", (7*W)'(result), mk7(2, 4, 6, 8, 10, 12, 0));

    // Back-to-back: start raised during DONE with scalar 3
    @(negedge clk);
    scalar = W'(3);
    start = 1'b1;
    run_op(1'b0, 1'b0, -1, cyc, bcyc, a3, b3);
    chk("b2b_done_cycle", (7*W)'(cyc), (7*W)'(8));
    chk("b2b_result", (7*W)'(result), mk7(3, 6, 9, 12, 15, 18, 0));
    go_idle();

    // Mode 1, element-wise
    set_rows(1, 1, 9);
    start = 1'b1;
    run_op(1'b0, 1'b0, -1, cyc, bcyc, a3, b3);
    chk("m1_done_cycle", (7*W)'(cyc), (7*W)'(8));
    chk("m1_result", (7*W)'(result), mk7(6, 10, 12, 12, 10, 6, 0));
    go_idle();

    // Mode 0 with en toggling and a spurious start mid-operation
    set_rows(1, 0, 2);
    mode = 1'b0;
    start = 1'b1;
    run_op(1'b0, 1'b1, 3, cyc, bcyc, a3, b3);
    chk("tog_done_cycle", (7*W)'(cyc), (7*W)'(8));
    chk("tog_busy_cycles", (7*W)'(bcyc), (7*W)'(7));
    chk("tog_result", (7*W)'(result), mk7(2, 4, 6, 8, 10, 12, 0));
    go_idle();

    // Reset while draining, then a fresh operation with scalar 1
    set_rows(1, 0, 2);
    mode = 1'b0;
    start = 1'b1;
    dseen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      if (done) dseen = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_busy", (7*W)'(busy), (7*W)'(1));
    rst = 1'b1;
    @(posedge clk);
    #2;
    if (done) dseen = 1'b1;
    chk("rst_result", (7*W)'(result), '0);
    chk("rst_busy", (7*W)'(busy), '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      if (done) dseen = 1'b1;
    end
    chk("rst_no_done", (7*W)'(dseen), '0);
    chk("rst_result_after_stale", (7*W)'(result), '0);
    @(negedge clk);
    scalar = W'(1);
    start = 1'b1;
    run_op(1'b0, 1'b0, -1, cyc, bcyc, a3, b3);
    chk("post_rst_done_cycle", (7*W)'(cyc), (7*W)'(8));
    chk("post_rst_result", (7*W)'(result), mk7(1, 2, 3, 4, 5, 6, 0));
    go_idle();

    // N=7 instance: three beats, last beat uses only lane 0
    for (int i = 0; i < 7; i++) row_a7[i*W +: W] = W'(i + 1);
    scalar7 = W'(2);
    mode = 1'b0;
    start7 = 1'b1;
    run_op(1'b1, 1'b0, -1, cyc, bcyc, a3, b3);
    chk("n7_beat2_dataa", (7*W)'(a3), mk7(7, 0, 0, 0, 0, 0, 0));
    chk("n7_beat2_datab", (7*W)'(b3), mk7(2, 0, 0, 0, 0, 0, 0));
    chk("n7_done_cycle", (7*W)'(cyc), (7*W)'(9));
    chk("n7_busy_cycles", (7*W)'(bcyc), (7*W)'(8));
    chk("n7_result", result7, mk7(2, 4, 6, 8, 10, 12, 14));
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
